// File: rtl/sdu_uart_tx.sv
// rtl/sdu_uart_tx.sv - SDU debug link UART transmitter with byte FIFO
// Build option: SDU_UART_TX_PARITY_EN adds an even parity bit (8E1); default frame is 8N1.
module sdu_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  din,
  input  logic                        din_vld,
  output logic                        din_rdy,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SDU_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // byte FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          empty;

  // transmit engine
  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud_cnt;
  logic          baud_done;
  logic          baud_clr;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          shift_en;
  logic          txd_next;
  logic          line_act;
`ifdef SDU_UART_TX_PARITY_EN
  logic          par_bit;
`endif

  // Ready comes from the registered count only, so a full FIFO refuses a push even while popping.
  assign din_rdy   = (cnt < CW'(FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign push      = din_vld && din_rdy;
  assign fifo_cnt  = cnt;
  assign baud_done = (baud_cnt == BW'(DIV - 1));

  // line_act lags the FSM by one cycle like txd, so busy covers the full last stop bit on the pin
  assign busy = line_act || (state != ST_IDLE) || !empty;

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, pop request and line level for the current frame position
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    baud_clr   = 1'b0;
    shift_en   = 1'b0;
    txd_next   = 1'b1;
    case (state)
      ST_IDLE: begin
        txd_next = 1'b1;
        baud_clr = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        txd_next = 1'b0;
        if (baud_done) begin
          baud_clr   = 1'b1;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_next = shift[0];
        if (baud_done) begin
          baud_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef SDU_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef SDU_UART_TX_PARITY_EN
      ST_PARITY: begin
        txd_next = par_bit;
        if (baud_done) begin
          baud_clr   = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        txd_next = 1'b1;
        if (baud_done) begin
          baud_clr = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bit timing, shift register and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      line_act <= 1'b0;
    end else begin
      txd      <= txd_next;
      line_act <= (state != ST_IDLE);
      if (baud_clr) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef SDU_UART_TX_PARITY_EN
  // Even parity captured from the byte as it is popped, before shifting destroys it
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (pop) begin
      par_bit <= ^mem[rd_ptr];
    end
  end
`endif

endmodule
